// File: rtl/reg_file_rename.sv
// Architectural register file with per-register ROB rename tags.
// Resolves issue operands combinationally; retires commits, renames at issue and drops all tags on flush.
module reg_file_rename #(
    parameter int REG_BIT = 5,
    parameter int ROB_BIT = 4,
    parameter int DAT_W   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               flush_i,
    input  logic               is_en_i,
    input  logic               is_wr_i,
    input  logic [REG_BIT-1:0] is_rs1_i,
    input  logic [REG_BIT-1:0] is_rs2_i,
    input  logic [REG_BIT-1:0] is_rd_i,
    input  logic [ROB_BIT-1:0] is_q_i,
    output logic [DAT_W-1:0]   is_vj_o,
    output logic [ROB_BIT-1:0] is_qj_o,
    output logic [DAT_W-1:0]   is_vk_o,
    output logic [ROB_BIT-1:0] is_qk_o,
    input  logic               cmt_en_i,
    input  logic [REG_BIT-1:0] cmt_rd_i,
    input  logic [ROB_BIT-1:0] cmt_q_i,
    input  logic [DAT_W-1:0]   cmt_v_i,
    output logic [ROB_BIT-1:0] rob_reqqj_o,
    output logic [ROB_BIT-1:0] rob_reqqk_o,
    input  logic               rob_rdyj_i,
    input  logic               rob_rdyk_i,
    input  logic [DAT_W-1:0]   rob_vj_i,
    input  logic [DAT_W-1:0]   rob_vk_i
);
    localparam int NREG = 1 << REG_BIT;

    logic [DAT_W-1:0]   r_val [NREG];
    logic [ROB_BIT-1:0] r_tag [NREG];

    logic [DAT_W+ROB_BIT-1:0] w_res_j;
    logic [DAT_W+ROB_BIT-1:0] w_res_k;
    logic [ROB_BIT-1:0]       w_tag_j;
    logic [ROB_BIT-1:0]       w_tag_k;
    logic                     w_cmt_wr;
    logic                     w_ren_wr;

    // Priority: x0, same-cycle commit forward, architectural value, ROB ready data, pending tag.
    function automatic logic [DAT_W+ROB_BIT-1:0] f_resolve(
        input logic [REG_BIT-1:0] rs,
        input logic [ROB_BIT-1:0] tag,
        input logic [DAT_W-1:0]   val,
        input logic               rdy,
        input logic [DAT_W-1:0]   rob_v,
        input logic               c_en,
        input logic [REG_BIT-1:0] c_rd,
        input logic [ROB_BIT-1:0] c_q,
        input logic [DAT_W-1:0]   c_v
    );
        logic [DAT_W+ROB_BIT-1:0] res;
        if (rs == '0)
            res = '0;
        else if (c_en && (c_rd == rs) && (tag != '0) && (c_q == tag))
            res = {c_v, {ROB_BIT{1'b0}}};
        else if (tag == '0)
            res = {val, {ROB_BIT{1'b0}}};
        else if (rdy)
            res = {rob_v, {ROB_BIT{1'b0}}};
        else
            res = {{DAT_W{1'b0}}, tag};
        return res;
    endfunction

    assign w_tag_j     = r_tag[is_rs1_i];
    assign w_tag_k     = r_tag[is_rs2_i];
    assign rob_reqqj_o = w_tag_j;
    assign rob_reqqk_o = w_tag_k;

    assign w_res_j = f_resolve(is_rs1_i, w_tag_j, r_val[is_rs1_i], rob_rdyj_i, rob_vj_i,
                               cmt_en_i, cmt_rd_i, cmt_q_i, cmt_v_i);
    assign w_res_k = f_resolve(is_rs2_i, w_tag_k, r_val[is_rs2_i], rob_rdyk_i, rob_vk_i,
                               cmt_en_i, cmt_rd_i, cmt_q_i, cmt_v_i);

    assign {is_vj_o, is_qj_o} = w_res_j;
    assign {is_vk_o, is_qk_o} = w_res_k;

    assign w_cmt_wr = cmt_en_i && (cmt_rd_i != '0);
    assign w_ren_wr = is_en_i && is_wr_i && (is_rd_i != '0) && !flush_i;

    // Later assignments win: commit clear, then rename, then flush of all tags.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_val[i] <= '0;
                r_tag[i] <= '0;
            end
        end else if (en) begin
            if (w_cmt_wr) begin
                r_val[cmt_rd_i] <= cmt_v_i;
                if (r_tag[cmt_rd_i] == cmt_q_i)
                    r_tag[cmt_rd_i] <= '0;
            end
            if (w_ren_wr)
                r_tag[is_rd_i] <= is_q_i;
            if (flush_i) begin
                for (int i = 0; i < NREG; i++)
                    r_tag[i] <= '0;
            end
        end
    end

endmodule

// File: tb/tb_reg_file_rename.sv
// Directed table-driven bench for reg_file_rename: each row drives one cycle,
// checks the combinational outputs before the edge, then lets the edge update state.
module tb_reg_file_rename;
    logic        clk = 1'b0;
    logic        rst, en, flush_i, is_en_i, is_wr_i;
    logic [4:0]  is_rs1_i, is_rs2_i, is_rd_i, cmt_rd_i;
    logic [3:0]  is_q_i, cmt_q_i, is_qj_o, is_qk_o, rob_reqqj_o, rob_reqqk_o;
    logic [31:0] is_vj_o, is_vk_o, cmt_v_i, rob_vj_i, rob_vk_i;
    logic        cmt_en_i, rob_rdyj_i, rob_rdyk_i;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    reg_file_rename #(.REG_BIT(5), .ROB_BIT(4), .DAT_W(32)) dut (
        .clk(clk), .rst(rst), .en(en), .flush_i(flush_i),
        .is_en_i(is_en_i), .is_wr_i(is_wr_i),
        .is_rs1_i(is_rs1_i), .is_rs2_i(is_rs2_i), .is_rd_i(is_rd_i), .is_q_i(is_q_i),
        .is_vj_o(is_vj_o), .is_qj_o(is_qj_o), .is_vk_o(is_vk_o), .is_qk_o(is_qk_o),
        .cmt_en_i(cmt_en_i), .cmt_rd_i(cmt_rd_i), .cmt_q_i(cmt_q_i), .cmt_v_i(cmt_v_i),
        .rob_reqqj_o(rob_reqqj_o), .rob_reqqk_o(rob_reqqk_o),
        .rob_rdyj_i(rob_rdyj_i), .rob_rdyk_i(rob_rdyk_i),
        .rob_vj_i(rob_vj_i), .rob_vk_i(rob_vk_i)
    );

    typedef struct {
        logic        rst, en, flush, ise, iswr;
        logic [4:0]  rs1, rs2, rd;
        logic [3:0]  q;
        logic        cen;
        logic [4:0]  crd;
        logic [3:0]  cq;
        logic [31:0] cv;
        logic        rdyj, rdyk;
        logic [31:0] rvj, rvk;
        logic [31:0] evj;
        logic [3:0]  eqj;
        logic [31:0] evk;
        logic [3:0]  eqk, erj, erk;
    } vec_t;

    function automatic vec_t mk(
        int r, int e, int f, int ie, int iw, int s1, int s2, int d, int q,
        int ce, int crd, int cq, int cv, int rj, int rk, int rvj, int rvk,
        int evj, int eqj, int evk, int eqk, int erj, int erk);
        vec_t v;
        v.rst = 1'(r);   v.en = 1'(e);    v.flush = 1'(f); v.ise = 1'(ie); v.iswr = 1'(iw);
        v.rs1 = 5'(s1);  v.rs2 = 5'(s2);  v.rd = 5'(d);    v.q = 4'(q);
        v.cen = 1'(ce);  v.crd = 5'(crd); v.cq = 4'(cq);   v.cv = 32'(cv);
        v.rdyj = 1'(rj); v.rdyk = 1'(rk); v.rvj = 32'(rvj); v.rvk = 32'(rvk);
        v.evj = 32'(evj); v.eqj = 4'(eqj); v.evk = 32'(evk); v.eqk = 4'(eqk);
        v.erj = 4'(erj); v.erk = 4'(erk);
        return v;
    endfunction

    task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %h, expected %h", name, row, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst = v.rst; en = v.en; flush_i = v.flush; is_en_i = v.ise; is_wr_i = v.iswr;
        is_rs1_i = v.rs1; is_rs2_i = v.rs2; is_rd_i = v.rd; is_q_i = v.q;
        cmt_en_i = v.cen; cmt_rd_i = v.crd; cmt_q_i = v.cq; cmt_v_i = v.cv;
        rob_rdyj_i = v.rdyj; rob_rdyk_i = v.rdyk; rob_vj_i = v.rvj; rob_vk_i = v.rvk;
    endtask

    vec_t vecs[20];
    vec_t idle;

    initial begin
        // rst en fl ie iw | rs1 rs2 rd q | cen crd cq cv | rdyj rdyk rvj rvk | evj eqj evk eqk erj erk
        vecs[0]  = mk(1,1,0,1,1, 5,0,3,4, 0,0,0,0,       0,0,0,0,       0,0,0,0,0,0);
        vecs[1]  = mk(0,1,0,1,1, 3,0,3,4, 0,0,0,0,       0,0,0,0,       0,0,0,0,0,0);
        vecs[2]  = mk(0,1,0,0,0, 3,0,0,0, 0,0,0,0,       0,0,0,0,       0,4,0,0,4,0);
        vecs[3]  = mk(0,1,0,0,0, 3,3,0,0, 0,0,0,0,       1,0,'h55,0,    'h55,0,0,4,4,4);
        vecs[4]  = mk(0,1,0,0,0, 3,3,0,0, 1,3,4,'hDEAD,  1,0,'h55,0,    'hDEAD,0,'hDEAD,0,4,4);
        vecs[5]  = mk(0,1,0,1,1, 3,0,3,4, 0,0,0,0,       0,0,0,0,       'hDEAD,0,0,0,0,0);
        vecs[6]  = mk(0,1,0,1,1, 3,0,3,7, 1,3,4,1,       0,0,0,0,       1,0,0,0,4,0);
        vecs[7]  = mk(0,1,0,0,0, 3,0,0,0, 1,3,4,2,       0,0,0,0,       0,7,0,0,7,0);
        vecs[8]  = mk(0,1,0,0,0, 3,3,0,0, 0,0,0,0,       0,1,0,'h77,    0,7,'h77,0,7,7);
        vecs[9]  = mk(0,1,0,0,0, 0,0,0,0, 1,3,7,3,       0,0,0,0,       0,0,0,0,0,0);
        vecs[10] = mk(0,1,0,1,1, 3,0,1,1, 0,0,0,0,       0,0,0,0,       3,0,0,0,0,0);
        vecs[11] = mk(0,1,0,1,1, 0,0,2,2, 0,0,0,0,       0,0,0,0,       0,0,0,0,0,0);
        vecs[12] = mk(0,1,0,1,1, 1,2,9,9, 0,0,0,0,       0,0,0,0,       0,1,0,2,1,2);
        vecs[13] = mk(0,1,1,1,1, 9,1,9,5, 1,1,1,'h10,    0,0,0,0,       0,9,'h10,0,9,1);
        vecs[14] = mk(0,1,0,1,1, 1,9,0,5, 1,0,0,'hFF,    0,0,0,0,       'h10,0,0,0,0,0);
        vecs[15] = mk(0,0,0,1,1, 0,2,4,6, 1,1,0,'h99,    0,0,0,0,       0,0,0,0,0,0);
        vecs[16] = mk(0,1,0,0,0, 4,1,0,0, 0,0,0,0,       0,0,0,0,       0,0,'h10,0,0,0);
        vecs[17] = mk(0,1,0,1,1, 0,0,5,3, 0,0,0,0,       0,0,0,0,       0,0,0,0,0,0);
        vecs[18] = mk(1,1,0,0,0, 5,0,0,0, 0,0,0,0,       0,0,0,0,       0,3,0,0,3,0);
        vecs[19] = mk(0,1,0,0,0, 5,1,0,0, 0,0,0,0,       0,0,0,0,       0,0,0,0,0,0);
        idle     = mk(0,1,0,0,0, 0,0,0,0, 0,0,0,0,       0,0,0,0,       0,0,0,0,0,0);

        drive(vecs[0]);
        repeat (2) @(posedge clk);

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            chk("vj",   i, is_vj_o,            vecs[i].evj);
            chk("qj",   i, 32'(is_qj_o),       32'(vecs[i].eqj));
            chk("vk",   i, is_vk_o,            vecs[i].evk);
            chk("qk",   i, 32'(is_qk_o),       32'(vecs[i].eqk));
            chk("reqj", i, 32'(rob_reqqj_o),   32'(vecs[i].erj));
            chk("reqk", i, 32'(rob_reqqk_o),   32'(vecs[i].erk));
        end

        // Commit with en low must not land; the same commit with en high must.
        @(negedge clk);
        drive(idle);
        en = 1'b0; cmt_en_i = 1'b1; cmt_rd_i = 5'd1; cmt_q_i = 4'd0; cmt_v_i = 32'hAA;
        @(negedge clk);
        drive(idle);
        is_rs1_i = 5'd1;
        #1;
        chk("en0_commit_held", 20, is_vj_o, 32'h0);
        en = 1'b1; cmt_en_i = 1'b1; cmt_rd_i = 5'd1; cmt_q_i = 4'd0; cmt_v_i = 32'hAA;
        @(negedge clk);
        drive(idle);
        is_rs1_i = 5'd1; is_rs2_i = 5'd1;
        #1;
        chk("en1_commit_vj", 21, is_vj_o, 32'hAA);
        chk("en1_commit_vk", 21, is_vk_o, 32'hAA);
        chk("en1_commit_qj", 21, 32'(is_qj_o), 32'h0);

        // Rename, then a pending tag with ROB not ready on rs2 only.
        is_en_i = 1'b1; is_wr_i = 1'b1; is_rd_i = 5'd7; is_q_i = 4'd15;
        @(negedge clk);
        drive(idle);
        is_rs1_i = 5'd7; is_rs2_i = 5'd7; rob_rdyj_i = 1'b1; rob_vj_i = 32'h1234;
        #1;
        chk("rdy_split_vj", 22, is_vj_o, 32'h1234);
        chk("rdy_split_qk", 22, 32'(is_qk_o), 32'd15);
        chk("rdy_split_reqk", 22, 32'(rob_reqqk_o), 32'd15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
